square_motion: RTL and testbench
================================

SQUARE_MOTION -- requirements
Module: square_motion

Interface
REQ-001 SHALL provide parameters (name, default, meaning):
- CLK_HZ, 25_175_000, step-accumulator modulus in cycles per second
- SERVE_CYCLES, 25_175_000, centre hold time after a miss or game start
- SQ_SIZE, 12, square side in pixels
- H_ACTIVE, 640, screen width
- V_ACTIVE, 480, screen height
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk_0  in  1  25.175MHz clock
- rst  in  1  reset; asynchronous, active-high
- game_run  in  1  play enabled
- sq_xvel  in  9  horizontal speed magnitude, px/s
- sq_yvel  in  9  vertical speed magnitude, px/s
- pdl_hit_l  in  1  one-cycle pulse: square touched left paddle
- pdl_hit_r  in  1  one-cycle pulse: square touched right paddle
- hit_below  in  1  valid with a hit pulse; 1 = contact below paddle centre
- sq_x  out  10  square left edge
- sq_y  out  10  square top edge
- dir_x  out  1  1 = moving right
- dir_y  out  1  1 = moving down
- sq_missed  out  1  one-cycle pulse on an out-of-bounds event
- miss_side  out  1  0 = left edge crossed, 1 = right edge; valid with sq_missed

Function
REQ-003 SHALL implement the FSM states IDLE, SERVE and PLAY.
REQ-004 SHALL transition as follows:
- IDLE -> SERVE when game_run=1
- any state -> IDLE when game_run=0, same cycle
- SERVE -> PLAY after SERVE_CYCLES cycles in SERVE
- PLAY -> SERVE on a miss
REQ-005 SHALL, in IDLE and SERVE, hold sq_x=(H_ACTIVE-SQ_SIZE)/2=314 and sq_y=(V_ACTIVE-SQ_SIZE)/2=234, hold both accumulators at 0 and hold the serve counter reset in IDLE.
REQ-006 SHALL, in PLAY, add the axis velocity to each 25-bit accumulator every cycle; when sum >= CLK_HZ, store sum-CLK_HZ and assert a one-cycle step for that axis, otherwise store sum.
REQ-007 SHALL produce at most one step per axis per cycle, which is guaranteed because the velocity is below CLK_HZ; velocity 0 SHALL never step.
REQ-008 SHALL, on a Y step, move sq_y by 1 in the dir_y direction, except:
- dir_y=0 and sq_y=0: dir_y becomes 1 and sq_y holds
- dir_y=1 and sq_y=V_ACTIVE-SQ_SIZE: dir_y becomes 0 and sq_y holds
REQ-009 SHALL, on an X step, move sq_x by 1 in dir_x, except:
- dir_x=0 and sq_x=0: miss, miss_side=0
- dir_x=1 and sq_x=H_ACTIVE-SQ_SIZE: miss, miss_side=1
REQ-010 SHALL, on a miss, pulse sq_missed for exactly one cycle, set dir_x toward the side that missed, enter SERVE and recentre on the next cycle.
REQ-011 SHALL accept pdl_hit_l only when dir_x=0 in PLAY; it sets dir_x=1 and dir_y=hit_below. pdl_hit_r SHALL be accepted only when dir_x=1; it sets dir_x=0 and dir_y=hit_below. Hit pulses in any other condition SHALL be ignored, which prevents double bounces.
REQ-012 SHALL, when an accepted hit and an X step coincide, apply the hit and suppress that X step (no position change, no miss); the accumulator still updates.
REQ-013 SHALL, when an accepted hit and a Y step coincide, take dir_y from hit_below and suppress that Y step.
REQ-014 SHALL use velocity values sampled in the same cycle, with no internal velocity register; latency from a velocity change to the accumulator is 1 cycle.
REQ-015 SHALL register all outputs; sq_missed SHALL never be asserted outside PLAY.

Reset
REQ-016 SHALL, while rst=1 (asynchronous), force state=IDLE, sq_x=314, sq_y=234, dir_x=1, dir_y=1, sq_missed=0, miss_side=0, accumulators=0 and serve counter=0.
REQ-017 SHALL, on rst asserted mid-PLAY, lose any pending step or miss; the first cycle after deassertion behaves as IDLE.

Structure
REQ-018 SHALL take H_ACTIVE, V_ACTIVE, SQ_SIZE and CLK_HZ from the shared pong constants include used by the display and game blocks.
REQ-019 SHALL instantiate the sub-module axis_stepper (accumulator, compare, step pulse, clear input) twice, once per axis.
REQ-020 SHALL keep the FSM, bounce/miss logic and serve counter in square_motion.

Verification (CLK_HZ=1000, SERVE_CYCLES=20 for simulation)
REQ-021 SHALL cover these scenarios:
- Reset, then game_run=1 -> square at (314,234) for 20 cycles, then PLAY; with xvel=200, first X step at cycle 5 of PLAY, sq_x=315.
- xvel=0, yvel=500, dir_y=0 from sq_y=1 -> steps to 0, next step flips dir_y=1 with sq_y held at 0, following step gives sq_y=1.
- dir_x=0, sq_x=0, X step -> sq_missed high exactly 1 cycle, miss_side=0, dir_x=0, next cycle SERVE at (314,234).
- pdl_hit_l with dir_x=0, hit_below=0 -> dir_x=1, dir_y=0; a second pdl_hit_l next cycle -> no change.
- Hit coincident with X step at sq_x=0 -> no miss, dir_x=1, sq_x stays 0.
- rst pulsed mid-PLAY -> outputs return to reset values immediately, independent of clk_0; game_run=0 mid-PLAY -> IDLE and centre next cycle.

Source files
------------

// File: rtl/square_motion_pkg.sv
// Shared pong constants, FSM state type and geometry helper for the square motion block.
package square_motion_pkg;

    localparam int unsigned PONG_CLK_HZ       = 25_175_000;
    localparam int unsigned PONG_H_ACTIVE     = 640;
    localparam int unsigned PONG_V_ACTIVE     = 480;
    localparam int unsigned PONG_SQ_SIZE      = 12;
    localparam int unsigned PONG_SERVE_CYCLES = 25_175_000;

    localparam int unsigned ACC_W = 25;
    localparam int unsigned POS_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2
    } state_t;

    // Top-left coordinate that centres a square of side 'size' within 'extent'.
    function automatic logic [POS_W-1:0] centre_pos(input int unsigned extent,
                                                    input int unsigned size);
        return POS_W'((extent - size) / 2);
    endfunction

endpackage

// File: rtl/square_motion_axis_stepper.sv
// Fractional-rate step generator: accumulates px/s velocity and emits one-cycle step pulses.
module axis_stepper
    import square_motion_pkg::*;
#(
    parameter int unsigned MODULUS = PONG_CLK_HZ
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [8:0] vel,
    output logic       step_c
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic             wrap;

    // One spare bit keeps the compare exact even at the largest modulus.
    always_comb begin
        sum    = {1'b0, acc} + (ACC_W + 1)'(vel);
        wrap   = (sum >= (ACC_W + 1)'(MODULUS));
        step_c = en && wrap;
    end

    always_ff @(posedge clk_0 or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            if (wrap) begin
                acc <= ACC_W'(sum - (ACC_W + 1)'(MODULUS));
            end else begin
                acc <= ACC_W'(sum);
            end
        end
    end

endmodule

// File: rtl/square_motion.sv
// Square (ball) motion for pong: serve/play FSM, wall bounce, paddle hits and miss detection.
module square_motion
    import square_motion_pkg::*;
#(
    parameter int unsigned CLK_HZ       = PONG_CLK_HZ,
    parameter int unsigned SERVE_CYCLES = PONG_SERVE_CYCLES,
    parameter int unsigned SQ_SIZE      = PONG_SQ_SIZE,
    parameter int unsigned H_ACTIVE     = PONG_H_ACTIVE,
    parameter int unsigned V_ACTIVE     = PONG_V_ACTIVE
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       game_run,
    input  logic [8:0] sq_xvel,
    input  logic [8:0] sq_yvel,
    input  logic       pdl_hit_l,
    input  logic       pdl_hit_r,
    input  logic       hit_below,
    output logic [9:0] sq_x,
    output logic [9:0] sq_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic       sq_missed,
    output logic       miss_side
);

    localparam int unsigned CNT_W = $clog2(SERVE_CYCLES + 1);

    localparam logic [POS_W-1:0] X_MAX = POS_W'(H_ACTIVE - SQ_SIZE);
    localparam logic [POS_W-1:0] Y_MAX = POS_W'(V_ACTIVE - SQ_SIZE);
    localparam logic [POS_W-1:0] X_CTR = centre_pos(H_ACTIVE, SQ_SIZE);
    localparam logic [POS_W-1:0] Y_CTR = centre_pos(V_ACTIVE, SQ_SIZE);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_CYCLES - 1);

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] serve_cnt;

    logic             step_x_c;
    logic             step_y_c;
    logic             acc_en;
    logic             acc_clr;

    logic             play_c;
    logic             hit_l_ok;
    logic             hit_r_ok;
    logic             hit_ok;
    logic             miss_c;
    logic             miss_side_c;
    logic [POS_W-1:0] x_d;
    logic [POS_W-1:0] y_d;
    logic             dir_x_d;
    logic             dir_y_d;

    // Accumulators only run in PLAY and are zeroed whenever play is about to stop.
    assign acc_en  = (state == ST_PLAY);
    assign acc_clr = (state_d != ST_PLAY);

    axis_stepper #(
        .MODULUS (CLK_HZ)
    ) u_step_x (
        .clk_0  (clk_0),
        .rst    (rst),
        .clr    (acc_clr),
        .en     (acc_en),
        .vel    (sq_xvel),
        .step_c (step_x_c)
    );

    axis_stepper #(
        .MODULUS (CLK_HZ)
    ) u_step_y (
        .clk_0  (clk_0),
        .rst    (rst),
        .clr    (acc_clr),
        .en     (acc_en),
        .vel    (sq_yvel),
        .step_c (step_y_c)
    );

    // Next position/direction; a paddle hit overrides any coincident step on both axes.
    always_comb begin
        x_d         = sq_x;
        y_d         = sq_y;
        dir_x_d     = dir_x;
        dir_y_d     = dir_y;
        miss_c      = 1'b0;
        miss_side_c = miss_side;
        play_c      = (state == ST_PLAY) && game_run;
        hit_l_ok    = play_c && pdl_hit_l && !dir_x;
        hit_r_ok    = play_c && pdl_hit_r && dir_x;
        hit_ok      = hit_l_ok || hit_r_ok;

        if (!play_c) begin
            x_d = X_CTR;
            y_d = Y_CTR;
        end else begin
            if (hit_ok) begin
                dir_y_d = hit_below;
            end else if (step_y_c) begin
                if (!dir_y) begin
                    if (sq_y == '0) begin
                        dir_y_d = 1'b1;
                    end else begin
                        y_d = sq_y - POS_W'(1);
                    end
                end else begin
                    if (sq_y == Y_MAX) begin
                        dir_y_d = 1'b0;
                    end else begin
                        y_d = sq_y + POS_W'(1);
                    end
                end
            end

            if (hit_ok) begin
                dir_x_d = hit_l_ok;
            end else if (step_x_c) begin
                if (!dir_x) begin
                    if (sq_x == '0) begin
                        miss_c      = 1'b1;
                        miss_side_c = 1'b0;
                        dir_x_d     = 1'b0;
                    end else begin
                        x_d = sq_x - POS_W'(1);
                    end
                end else begin
                    if (sq_x == X_MAX) begin
                        miss_c      = 1'b1;
                        miss_side_c = 1'b1;
                        dir_x_d     = 1'b1;
                    end else begin
                        x_d = sq_x + POS_W'(1);
                    end
                end
            end
        end
    end

    // Next-state logic; dropping game_run wins over every other transition.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (game_run) begin
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (serve_cnt == SERVE_LAST) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (miss_c) begin
                    state_d = ST_SERVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (!game_run) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_0 or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Counts cycles spent in SERVE; cleared on any exit.
    always_ff @(posedge clk_0 or posedge rst) begin
        if (rst) begin
            serve_cnt <= '0;
        end else if ((state == ST_SERVE) && (state_d == ST_SERVE)) begin
            serve_cnt <= serve_cnt + CNT_W'(1);
        end else begin
            serve_cnt <= '0;
        end
    end

    always_ff @(posedge clk_0 or posedge rst) begin
        if (rst) begin
            sq_x      <= X_CTR;
            sq_y      <= Y_CTR;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            sq_missed <= 1'b0;
            miss_side <= 1'b0;
        end else begin
            sq_x      <= x_d;
            sq_y      <= y_d;
            dir_x     <= dir_x_d;
            dir_y     <= dir_y_d;
            sq_missed <= miss_c;
            miss_side <= miss_side_c;
        end
    end

endmodule

// File: tb/tb_square_motion.sv
// Directed bench for square_motion with a fast clock modulus and short serve time.
module tb_square_motion;

    logic       clk_0 = 1'b0;
    logic       rst;
    logic       game_run;
    logic [8:0] sq_xvel;
    logic [8:0] sq_yvel;
    logic       pdl_hit_l;
    logic       pdl_hit_r;
    logic       hit_below;
    logic [9:0] sq_x;
    logic [9:0] sq_y;
    logic       dir_x;
    logic       dir_y;
    logic       sq_missed;
    logic       miss_side;

    int checks   = 0;
    int failures = 0;

    square_motion #(
        .CLK_HZ       (1000),
        .SERVE_CYCLES (20),
        .SQ_SIZE      (12),
        .H_ACTIVE     (640),
        .V_ACTIVE     (480)
    ) dut (
        .clk_0     (clk_0),
        .rst       (rst),
        .game_run  (game_run),
        .sq_xvel   (sq_xvel),
        .sq_yvel   (sq_yvel),
        .pdl_hit_l (pdl_hit_l),
        .pdl_hit_r (pdl_hit_r),
        .hit_below (hit_below),
        .sq_x      (sq_x),
        .sq_y      (sq_y),
        .dir_x     (dir_x),
        .dir_y     (dir_y),
        .sq_missed (sq_missed),
        .miss_side (miss_side)
    );

    always #5 clk_0 = ~clk_0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog timeout");
    end

    task automatic tick();
        @(posedge clk_0);
        #1;
    endtask

    task automatic do_reset();
        game_run  = 1'b0;
        pdl_hit_l = 1'b0;
        pdl_hit_r = 1'b0;
        hit_below = 1'b0;
        sq_xvel   = 9'd0;
        sq_yvel   = 9'd0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Leaves the DUT in PLAY with no PLAY cycle elapsed yet.
    task automatic start_game(input logic [8:0] xv, input logic [8:0] yv);
        do_reset();
        sq_xvel  = xv;
        sq_yvel  = yv;
        game_run = 1'b1;
        repeat (21) tick();
    endtask

    task automatic wait_x(input logic [9:0] v, input int budget, output bit found);
        int n = 0;
        found = 1'b0;
        while (!found && n < budget) begin
            tick();
            n++;
            if (sq_x == v) found = 1'b1;
        end
    endtask

    task automatic wait_y(input logic [9:0] v, input int budget, output bit found);
        int n = 0;
        found = 1'b0;
        while (!found && n < budget) begin
            tick();
            n++;
            if (sq_y == v) found = 1'b1;
        end
    endtask

    task automatic pulse_hit(input bit left, input logic below);
        hit_below = below;
        if (left) pdl_hit_l = 1'b1;
        else      pdl_hit_r = 1'b1;
        tick();
        pdl_hit_l = 1'b0;
        pdl_hit_r = 1'b0;
    endtask

    task automatic test_reset();
        game_run = 1'b0; pdl_hit_l = 1'b0; pdl_hit_r = 1'b0; hit_below = 1'b0;
        sq_xvel = 9'd0; sq_yvel = 9'd0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++; if (sq_x !== 10'd314) begin failures++; $display("FAIL reset_x: got %0d want 314", sq_x); end
        checks++; if (sq_y !== 10'd234) begin failures++; $display("FAIL reset_y: got %0d want 234", sq_y); end
        checks++; if (dir_x !== 1'b1) begin failures++; $display("FAIL reset_dir_x: got %b want 1", dir_x); end
        checks++; if (dir_y !== 1'b1) begin failures++; $display("FAIL reset_dir_y: got %b want 1", dir_y); end
        checks++; if (sq_missed !== 1'b0) begin failures++; $display("FAIL reset_missed: got %b want 0", sq_missed); end
        checks++; if (miss_side !== 1'b0) begin failures++; $display("FAIL reset_side: got %b want 0", miss_side); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_serve();
        do_reset();
        sq_xvel  = 9'd200;
        game_run = 1'b1;
        for (int k = 0; k < 25; k++) begin
            tick();
            checks++;
            if (sq_x !== 10'd314 || sq_y !== 10'd234) begin
                failures++;
                $display("FAIL serve_hold edge=%0d: got (%0d,%0d) want (314,234)", k, sq_x, sq_y);
            end
        end
        tick();
        checks++; if (sq_x !== 10'd315) begin failures++; $display("FAIL first_step: got %0d want 315", sq_x); end
        repeat (4) tick();
        checks++; if (sq_x !== 10'd315) begin failures++; $display("FAIL step_gap: got %0d want 315", sq_x); end
        tick();
        checks++; if (sq_x !== 10'd316) begin failures++; $display("FAIL second_step: got %0d want 316", sq_x); end
        checks++; if (sq_y !== 10'd234) begin failures++; $display("FAIL yvel0_hold: got %0d want 234", sq_y); end
    endtask

    task automatic test_paddle();
        do_reset();
        game_run = 1'b1;
        repeat (5) tick();
        pulse_hit(1'b0, 1'b0);
        checks++;
        if (dir_x !== 1'b1 || dir_y !== 1'b1) begin
            failures++; $display("FAIL hit_in_serve: got dir=(%b,%b) want (1,1)", dir_x, dir_y);
        end
        repeat (15) tick();
        pulse_hit(1'b1, 1'b1);
        checks++;
        if (dir_x !== 1'b1 || dir_y !== 1'b1) begin
            failures++; $display("FAIL hit_l_wrong_dir: got dir=(%b,%b) want (1,1)", dir_x, dir_y);
        end
        pulse_hit(1'b0, 1'b0);
        checks++;
        if (dir_x !== 1'b0 || dir_y !== 1'b0) begin
            failures++; $display("FAIL hit_r: got dir=(%b,%b) want (0,0)", dir_x, dir_y);
        end
        pulse_hit(1'b1, 1'b0);
        checks++;
        if (dir_x !== 1'b1 || dir_y !== 1'b0) begin
            failures++; $display("FAIL hit_l: got dir=(%b,%b) want (1,0)", dir_x, dir_y);
        end
        pulse_hit(1'b1, 1'b1);
        checks++;
        if (dir_x !== 1'b1 || dir_y !== 1'b0) begin
            failures++; $display("FAIL hit_l_double: got dir=(%b,%b) want (1,0)", dir_x, dir_y);
        end
        repeat (30) tick();
        checks++;
        if (sq_x !== 10'd314 || sq_y !== 10'd234) begin
            failures++; $display("FAIL vel0_no_step: got (%0d,%0d) want (314,234)", sq_x, sq_y);
        end
    endtask

    task automatic test_y_bounce();
        bit found;
        start_game(9'd0, 9'd0);
        pulse_hit(1'b0, 1'b0);
        sq_yvel = 9'd500;
        wait_y(10'd1, 1200, found);
        checks++; if (!found) begin failures++; $display("FAIL y_reach_1: sq_y=%0d want 1 within budget", sq_y); end
        tick();
        checks++; if (sq_y !== 10'd1) begin failures++; $display("FAIL y_gap: got %0d want 1", sq_y); end
        tick();
        checks++;
        if (sq_y !== 10'd0 || dir_y !== 1'b0) begin
            failures++; $display("FAIL y_to_0: got y=%0d dir_y=%b want 0,0", sq_y, dir_y);
        end
        repeat (2) tick();
        checks++;
        if (sq_y !== 10'd0 || dir_y !== 1'b1) begin
            failures++; $display("FAIL y_bounce: got y=%0d dir_y=%b want 0,1", sq_y, dir_y);
        end
        repeat (2) tick();
        checks++;
        if (sq_y !== 10'd1 || dir_y !== 1'b1) begin
            failures++; $display("FAIL y_after_bounce: got y=%0d dir_y=%b want 1,1", sq_y, dir_y);
        end
        checks++; if (sq_x !== 10'd314) begin failures++; $display("FAIL y_x_still: got %0d want 314", sq_x); end
    endtask

    task automatic test_miss();
        bit found;
        start_game(9'd0, 9'd0);
        pulse_hit(1'b0, 1'b0);
        sq_xvel = 9'd500;
        wait_x(10'd0, 1000, found);
        checks++; if (!found) begin failures++; $display("FAIL x_reach_0: sq_x=%0d want 0 within budget", sq_x); end
        tick();
        checks++; if (sq_missed !== 1'b0 || sq_x !== 10'd0) begin failures++; $display("FAIL pre_miss: got missed=%b x=%0d want 0,0", sq_missed, sq_x); end
        tick();
        checks++;
        if (sq_missed !== 1'b1 || miss_side !== 1'b0 || dir_x !== 1'b0) begin
            failures++; $display("FAIL miss_left: got missed=%b side=%b dir_x=%b want 1,0,0", sq_missed, miss_side, dir_x);
        end
        tick();
        checks++;
        if (sq_missed !== 1'b0 || sq_x !== 10'd314 || sq_y !== 10'd234) begin
            failures++; $display("FAIL miss_recentre: got missed=%b (%0d,%0d) want 0 (314,234)", sq_missed, sq_x, sq_y);
        end
        repeat (20) tick();
        checks++; if (sq_x !== 10'd314) begin failures++; $display("FAIL reserve_hold: got %0d want 314", sq_x); end
        tick();
        checks++; if (sq_x !== 10'd313) begin failures++; $display("FAIL reserve_step: got %0d want 313", sq_x); end
        pulse_hit(1'b1, 1'b0);
        checks++; if (dir_x !== 1'b1) begin failures++; $display("FAIL turn_right: got %b want 1", dir_x); end
        wait_x(10'd628, 1000, found);
        checks++; if (!found) begin failures++; $display("FAIL x_reach_628: sq_x=%0d want 628 within budget", sq_x); end
        tick();
        checks++; if (sq_missed !== 1'b0 || sq_x !== 10'd628) begin failures++; $display("FAIL pre_miss_r: got missed=%b x=%0d want 0,628", sq_missed, sq_x); end
        tick();
        checks++;
        if (sq_missed !== 1'b1 || miss_side !== 1'b1 || dir_x !== 1'b1) begin
            failures++; $display("FAIL miss_right: got missed=%b side=%b dir_x=%b want 1,1,1", sq_missed, miss_side, dir_x);
        end
        tick();
        checks++;
        if (sq_missed !== 1'b0 || sq_x !== 10'd314) begin
            failures++; $display("FAIL miss_r_recentre: got missed=%b x=%0d want 0,314", sq_missed, sq_x);
        end
    endtask

    task automatic test_hit_at_edge();
        bit found;
        start_game(9'd0, 9'd0);
        pulse_hit(1'b0, 1'b0);
        sq_xvel = 9'd500;
        wait_x(10'd0, 1000, found);
        checks++; if (!found) begin failures++; $display("FAIL edge_reach_0: sq_x=%0d want 0 within budget", sq_x); end
        tick();
        pulse_hit(1'b1, 1'b1);
        checks++;
        if (sq_missed !== 1'b0 || dir_x !== 1'b1 || dir_y !== 1'b1 || sq_x !== 10'd0) begin
            failures++;
            $display("FAIL hit_vs_step: got missed=%b dir=(%b,%b) x=%0d want 0 (1,1) 0", sq_missed, dir_x, dir_y, sq_x);
        end
        tick();
        checks++; if (sq_missed !== 1'b0 || sq_x !== 10'd0) begin failures++; $display("FAIL hit_vs_step_after: got missed=%b x=%0d want 0,0", sq_missed, sq_x); end
        tick();
        checks++; if (sq_x !== 10'd1) begin failures++; $display("FAIL hit_then_right: got %0d want 1", sq_x); end
    endtask

    task automatic test_rst_mid_play();
        start_game(9'd500, 9'd500);
        repeat (10) tick();
        checks++;
        if (sq_x !== 10'd319 || sq_y !== 10'd239) begin
            failures++; $display("FAIL play_diag: got (%0d,%0d) want (319,239)", sq_x, sq_y);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (sq_x !== 10'd314 || sq_y !== 10'd234 || dir_x !== 1'b1 || dir_y !== 1'b1 ||
            sq_missed !== 1'b0 || miss_side !== 1'b0) begin
            failures++;
            $display("FAIL async_rst: got (%0d,%0d) dir=(%b,%b) missed=%b side=%b want (314,234) (1,1) 0 0",
                     sq_x, sq_y, dir_x, dir_y, sq_missed, miss_side);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 22; k++) begin
            tick();
            checks++;
            if (sq_x !== 10'd314 || sq_missed !== 1'b0) begin
                failures++; $display("FAIL post_rst_idle edge=%0d: got x=%0d missed=%b want 314,0", k, sq_x, sq_missed);
            end
        end
        tick();
        checks++; if (sq_x !== 10'd315) begin failures++; $display("FAIL post_rst_play: got %0d want 315", sq_x); end
    endtask

    task automatic test_game_run_drop();
        start_game(9'd500, 9'd500);
        repeat (10) tick();
        game_run = 1'b0;
        tick();
        checks++;
        if (sq_x !== 10'd314 || sq_y !== 10'd234 || sq_missed !== 1'b0) begin
            failures++; $display("FAIL run_drop: got (%0d,%0d) missed=%b want (314,234) 0", sq_x, sq_y, sq_missed);
        end
        pulse_hit(1'b0, 1'b0);
        checks++; if (dir_x !== 1'b1 || dir_y !== 1'b1) begin failures++; $display("FAIL hit_in_idle: got dir=(%b,%b) want (1,1)", dir_x, dir_y); end
        repeat (5) tick();
        checks++; if (sq_x !== 10'd314 || sq_y !== 10'd234) begin failures++; $display("FAIL idle_hold: got (%0d,%0d) want (314,234)", sq_x, sq_y); end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_paddle();
        test_y_bounce();
        test_miss();
        test_hit_at_edge();
        test_rst_mid_play();
        test_game_run_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
